// File: rtl/alu_arbiter_pkg.sv
// Shared ALU datapath types plus the request/ID types used by the round-robin ALU arbiter.
package alu_arbiter_pkg;

    localparam int DATA_WIDTH       = 32;
    localparam int ALU_CODE_WIDTH   = 4;
    localparam int SHAMT_WIDTH      = $clog2(DATA_WIDTH);
    localparam int ALU_REQ_NUM_MAX  = 8;
    localparam int ALU_REQ_ID_WIDTH = 3;

    typedef logic [DATA_WIDTH-1:0]       DataPath;
    typedef logic [ALU_CODE_WIDTH-1:0]   ALUCodePath;
    typedef logic [ALU_REQ_ID_WIDTH-1:0] ALUReqIdPath;

    // Codes 10..15 are unassigned and make the ALU return 0.
    typedef enum logic [ALU_CODE_WIDTH-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } ALUCode;

    typedef struct packed {
        DataPath    aluInA;
        DataPath    aluInB;
        ALUCodePath code;
    } ALUReqPath;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared combinational integer ALU; unknown operation codes yield 0.
module ALU
    import alu_arbiter_pkg::*;
(
    input  DataPath    aluInA,
    input  DataPath    aluInB,
    input  ALUCodePath code,
    output DataPath    aluOut
);

    always_comb begin
        // NOTE: default assignment first so every path drives aluOut and no latch is inferred.
        aluOut = '0;
        case (code)
            ALU_ADD:  aluOut = aluInA + aluInB;
            ALU_SUB:  aluOut = aluInA - aluInB;
            ALU_AND:  aluOut = aluInA & aluInB;
            ALU_OR:   aluOut = aluInA | aluInB;
            ALU_XOR:  aluOut = aluInA ^ aluInB;
            ALU_SLL:  aluOut = aluInA << aluInB[SHAMT_WIDTH-1:0];
            ALU_SRL:  aluOut = aluInA >> aluInB[SHAMT_WIDTH-1:0];
            ALU_SRA:  aluOut = DataPath'($signed(aluInA) >>> aluInB[SHAMT_WIDTH-1:0]);
            ALU_SLT:  aluOut = DataPath'($signed(aluInA) < $signed(aluInB));
            ALU_SLTU: aluOut = DataPath'(aluInA < aluInB);
            default:  aluOut = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ requesters, with a single
// registered response channel that supports backpressure.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic       [NUM_REQ-1:0] reqValid,
    input  DataPath    [NUM_REQ-1:0] reqAluInA,
    input  DataPath    [NUM_REQ-1:0] reqAluInB,
    input  ALUCodePath [NUM_REQ-1:0] reqCode,
    output logic       [NUM_REQ-1:0] reqReady,
    output logic                     rspValid,
    output ALUReqIdPath              rspId,
    output DataPath                  rspData,
    input  logic                     rspReady
);

    ALUReqIdPath        rrPtr;
    ALUReqIdPath        win;
    ALUReqIdPath        nextPtr;
    logic [NUM_REQ-1:0] grantOneHot;
    logic               found;
    logic               stageReady;
    logic               accept;
    ALUReqPath          winReq;
    DataPath            aluOut;
    int                 idx;

    assign stageReady = !rspValid || rspReady;

    // Priority search from rrPtr upward with wrap; only constant indices touch the request vectors.
    always_comb begin
        found       = 1'b0;
        win         = '0;
        grantOneHot = '0;
        winReq      = '0;
        idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rrPtr) + k;
            if (idx >= NUM_REQ) idx -= NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && i == idx && reqValid[i]) begin
                    found          = 1'b1;
                    win            = ALUReqIdPath'(i);
                    grantOneHot[i] = 1'b1;
                    winReq         = '{aluInA: reqAluInA[i], aluInB: reqAluInB[i], code: reqCode[i]};
                end
            end
        end
    end

    assign reqReady = (found && stageReady && !rst) ? grantOneHot : '0;
    assign accept   = |reqReady;
    assign nextPtr  = (win == ALUReqIdPath'(NUM_REQ - 1)) ? '0 : win + 1'b1;

    ALU uAlu (
        .aluInA (winReq.aluInA),
        .aluInB (winReq.aluInB),
        .code   (winReq.code),
        .aluOut (aluOut)
    );

    // A drain and a new accept in the same cycle simply reload the register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rrPtr    <= '0;
            rspValid <= 1'b0;
            rspId    <= '0;
            rspData  <= '0;
        end else if (accept) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            rrPtr    <= nextPtr;
            rspValid <= 1'b1;
            rspId    <= win;
            rspData  <= aluOut;
        end else if (rspReady) begin
            rspValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: expected responses go into a queue, a negedge monitor checks them.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int N = 4;

    typedef struct packed {
        ALUReqIdPath id;
        DataPath     data;
    } RspEntry;

    logic                 clk = 1'b0;
    logic                 rst;
    logic       [N-1:0]   reqValid;
    DataPath    [N-1:0]   reqAluInA;
    DataPath    [N-1:0]   reqAluInB;
    ALUCodePath [N-1:0]   reqCode;
    logic       [N-1:0]   reqReady;
    logic                 rspValid;
    ALUReqIdPath          rspId;
    DataPath              rspData;
    logic                 rspReady;

    RspEntry expQ[$];
    RspEntry monEntry;
    DataPath expRes [N];
    int      nChecks = 0;
    int      nFail   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .reqValid  (reqValid),
        .reqAluInA (reqAluInA),
        .reqAluInB (reqAluInB),
        .reqCode   (reqCode),
        .reqReady  (reqReady),
        .rspValid  (rspValid),
        .rspId     (rspId),
        .rspData   (rspData),
        .rspReady  (rspReady)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic setReq(input logic [1:0] i, input DataPath a, input DataPath b,
                          input ALUCodePath c, input DataPath exp);
        reqAluInA[i] = a;
        reqAluInB[i] = b;
        reqCode[i]   = c;
        expRes[i]    = exp;
    endtask

    // One cycle: check the grant, queue the granted requester's result, then advance.
    task automatic step(input string name, input logic [N-1:0] expGrant, input logic clearOnGrant);
        @(negedge clk);
        check(name, reqReady, expGrant);
        for (int i = 0; i < N; i++) begin
            if (expGrant[i]) expQ.push_back('{id: ALUReqIdPath'(i), data: expRes[i[1:0]]});
        end
        @(posedge clk);
        #1;
        if (clearOnGrant) reqValid = reqValid & ~expGrant;
    endtask

    always @(negedge clk) begin
        if (!rst && rspValid && rspReady) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nFail++;
                $display("FAIL rsp_unexpected: got id %0d data %0h, expected no response", rspId, rspData);
            end else begin
                monEntry = expQ.pop_front();
                check("rsp_id", rspId, monEntry.id);
                check("rsp_data", rspData, monEntry.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        reqValid  = '0;
        reqAluInA = '0;
        reqAluInB = '0;
        reqCode   = '0;
        rspReady  = 1'b1;
        for (int i = 0; i < N; i++) expRes[i] = '0;

        repeat (2) @(posedge clk);
        #1 reqValid = '1;
        @(negedge clk);
        check("rst_no_grant", reqReady, 0);
        @(posedge clk);
        #1;
        reqValid = '0;
        rst      = 1'b0;
        @(negedge clk);
        check("rst_rspValid", rspValid, 0);
        check("rst_rspId", rspId, 0);
        check("rst_rspData", rspData, 0);
        check("rst_reqReady", reqReady, 0);
        @(posedge clk);
        #1;

        // First transaction and its one-cycle latency.
        setReq(2'd2, 32'd5, 32'd7, ALU_ADD, 32'd12);
        reqValid[2] = 1'b1;
        step("add_grant2", 4'b0100, 1'b1);
        @(negedge clk);
        check("add_latency_valid", rspValid, 1);
        check("add_latency_id", rspId, 2);
        check("add_latency_data", rspData, 12);
        @(posedge clk);
        #1;

        // Unknown code from requester 3 also brings the pointer back to 0.
        setReq(2'd3, 32'h1234, 32'h5678, 4'hF, 32'd0);
        reqValid[3] = 1'b1;
        step("unknown_grant3", 4'b1000, 1'b1);

        // Round robin with everyone requesting.
        setReq(2'd0, 32'd1, 32'd2, ALU_ADD, 32'd3);
        setReq(2'd1, 32'd10, 32'd4, ALU_SUB, 32'd6);
        setReq(2'd2, 32'hF0F0, 32'hFF00, ALU_AND, 32'hF000);
        setReq(2'd3, 32'h0F, 32'hF0, ALU_OR, 32'hFF);
        reqValid = '1;
        for (int k = 0; k < 8; k++) step("rr_grant", 4'(1 << (k % 4)), 1'b0);
        reqValid = '0;
        step("rr_idle", 4'b0000, 1'b1);

        // Backpressure: hold the SUB result while requester 3 waits.
        setReq(2'd1, 32'd3, 32'd5, ALU_SUB, 32'hFFFF_FFFE);
        reqValid[1] = 1'b1;
        step("bp_grant1", 4'b0010, 1'b1);
        rspReady = 1'b0;
        setReq(2'd3, 32'hFF, 32'h0F, ALU_XOR, 32'hF0);
        reqValid[3] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_hold_valid", rspValid, 1);
            check("bp_hold_data", rspData, 32'hFFFF_FFFE);
            check("bp_hold_id", rspId, 1);
            check("bp_no_grant", reqReady, 0);
            @(posedge clk);
            #1;
        end
        rspReady = 1'b1;
        step("bp_release_grant3", 4'b1000, 1'b1);

        // Drain and accept in the same cycle.
        setReq(2'd0, 32'd1, 32'd4, ALU_SLL, 32'd16);
        reqValid[0] = 1'b1;
        step("drain_grant0", 4'b0001, 1'b1);
        @(negedge clk);
        check("drain_keep_valid", rspValid, 1);
        @(posedge clk);
        #1;

        setReq(2'd2, 32'd2, 32'd9, ALU_SLT, 32'd1);
        reqValid[2] = 1'b1;
        step("slt_grant2", 4'b0100, 1'b1);
        step("slt_idle", 4'b0000, 1'b1);

        // Mid-operation reset with a held response and rrPtr at 2.
        setReq(2'd1, 32'h7FFF_FFFF, 32'd1, ALU_ADD, 32'h8000_0000);
        reqValid[1] = 1'b1;
        step("mid_grant1", 4'b0010, 1'b1);
        rspReady = 1'b0;
        @(negedge clk);
        check("mid_pre_valid", rspValid, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", rspValid, 0);
        check("mid_rst_data", rspData, 0);
        check("mid_rst_id", rspId, 0);
        expQ.delete();
        reqValid = '1;
        rspReady = 1'b1;
        #1;
        check("mid_rst_no_grant", reqReady, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        step("mid_first_grant0", 4'b0001, 1'b0);
        reqValid = '0;
        step("mid_idle", 4'b0000, 1'b1);

        check("queue_empty", 64'(expQ.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational ALU among `NUM_REQ` requesters, such as the integer pipe, the address-generation unit and the debug port. Arbitration is round-robin with a valid/ready handshake on every requester. The block registers the ALU result with the winning requester's index and returns it on a single response channel that supports backpressure. It sits between the issue logic and the shared ALU datapath.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; legal range 1..8.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `reqValid`  in  `NUM_REQ`  requester i has an operation pending.
- `reqAluInA`  in  `NUM_REQ` x `DATA_WIDTH`  operand A per requester.
- `reqAluInB`  in  `NUM_REQ` x `DATA_WIDTH`  operand B per requester.
- `reqCode`  in  `NUM_REQ` x `ALUCodePath`  ALU operation code per requester.
- `reqReady`  out  `NUM_REQ`  one-hot grant; requester i's operation is accepted this cycle.
- `rspValid`  out  1  the response register holds a result.
- `rspId`  out  `ALUReqIdPath`  index of the requester that owns the result.
- `rspData`  out  `DATA_WIDTH`  ALU result.
- `rspReady`  in  1  consumer accepts the response this cycle.

## Operation
- Stage-ready: `stageReady = !rspValid || rspReady`.
- Grant rule:
  - Search `reqValid` starting at round-robin pointer `rrPtr` and moving upward with wrap-around. The first asserted index wins.
  - `reqReady[win]` = `stageReady`. All other `reqReady` bits are 0.
  - `reqReady` is fully 0 when no request is valid or when `!stageReady`.
- Requester rules:
  - Operands and code must stay stable while `reqValid && !reqReady`.
  - A requester may deassert `reqValid` before it is granted. The bench does not exercise this case; the design must not hang when it happens.
- Accept, when any `reqReady` bit is set:
  - Drive the winner's operands and code into the ALU.
  - Load `rspData` with the ALU output and `rspId` with `win`.
  - Set `rspValid` to 1.
  - Set `rrPtr` to `(win + 1) mod NUM_REQ`.
- No accept but `rspReady && rspValid`: clear `rspValid`. `rspData` and `rspId` keep their values.
- Stall, when `rspValid && !rspReady`: `rspValid`, `rspData` and `rspId` must hold bit-stable, and no grant is issued.
- A simultaneous response drain and new accept in the same cycle is legal. `rspValid` stays 1 and the register takes the new result.
- An unknown `reqCode` produces a result of 0. It is still granted and returned as a normal response.
- `rrPtr` advances only on an accept. Idle cycles leave it unchanged.
- With `NUM_REQ = 1`, `rrPtr` is constantly 0 and `rspId` is constantly 0.

## Timing
- Reset values, applied asynchronously while `rst` is high: `rspValid` = 0, `rspData` = 0, `rspId` = 0, `rrPtr` = 0.
- `reqReady` is combinational from `reqValid`, `rrPtr`, `rspValid` and `rspReady`. It is forced to 0 while `rst` is high.
- Latency: an operation accepted in cycle t appears with `rspValid` = 1 in cycle t+1.
- Throughput: one operation per cycle while `rspReady` is held at 1.
- Fairness: a continuously valid requester is granted within `NUM_REQ` accepts.
- Reset mid-operation: the pending response is dropped and no grant occurs in the reset cycle. After `rst` deasserts, the first grant is made from pointer 0.
- There is no combinational path from `rspReady` to `rspValid`, `rspData` or `rspId`.

## Structure
- Shared package, next to the existing `DataPath`, `ALUCodePath` and `DATA_WIDTH`:
  - `ALU_REQ_NUM_MAX` = 8.
  - `ALU_REQ_ID_WIDTH` = 3.
  - `typedef logic [ALU_REQ_ID_WIDTH-1:0] ALUReqIdPath`.
  - `typedef struct packed { DataPath aluInA; DataPath aluInB; ALUCodePath code; } ALUReqPath`.
- One sub-module: instantiate the existing `ALU` unchanged. The arbiter's round-robin priority search stays inline.
- State is limited to `rrPtr`, `rspValid`, `rspId` and `rspData`.

## Test plan
- **Reset:** after reset with `reqValid` = 0, all outputs are 0. Assert `reqValid[2]` with an ADD of 5 and 7 and hold `rspReady` = 1. `reqReady` = 0100 in the same cycle, then `rspValid` = 1, `rspId` = 2, `rspData` = 12 one cycle later.
- **Round-robin:** hold `reqValid` = 1111 and `rspReady` = 1 for 8 cycles. Grants must follow the order 0,1,2,3,0,1,2,3, and `rspId` must follow the same sequence one cycle later.
- **Backpressure:**
  - Requester 1 issues a SUB of 3 and 5, and `rspReady` is held at 0 for 3 cycles.
  - `rspData` must stay at 0xFFFFFFFE with `rspId` = 1, and `reqReady` must stay 0 throughout.
  - When `rspReady` rises, the waiting requester 3 is granted in that same cycle.
- **Drain with accept:** `rspValid` = 1 and `rspReady` = 1 while `reqValid[0]` requests an SLL of 1 by 4. `rspValid` stays 1 and the next result is 16.
- **Corner cases:**
  - An unknown code from requester 3 returns `rspData` = 0 with `rspId` = 3.
  - An SLT of 2 and 9 returns 1.
- **Mid-operation reset:** assert `rst` asynchronously while `rspValid` = 1 and `rrPtr` = 2. Outputs clear immediately. After release, with `reqValid` = 1111, the first grant goes to requester 0.
